// File: rtl/vmem_stage_pkg.sv
// vmem_pkg: shared types and helpers for the vector memory stage.
//   vm_state_t    - stage FSM states (VM_IDLE, VM_PERI)
//   vm_is_peri()  - region decode: 1 when a byte address targets the peripheral bus
package vmem_pkg;

  typedef enum logic {
    VM_IDLE,
    VM_PERI
  } vm_state_t;

  // Addresses are zero-extended to 32 bits by the caller so one helper serves any ADDR_W <= 32.
  function automatic logic vm_is_peri(input logic [31:0] addr, input logic [31:0] base);
    return addr >= base;
  endfunction

endpackage

// File: rtl/vmem_stage_if.sv
// vmem_stage_if: peripheral req/ack bus between vmem_stage (master) and a peripheral (slave).
//   peri_req_o   - request, held until ack or timeout
//   peri_we_o    - 1 = write
//   peri_addr_o  - byte address
//   peri_wdata_o - write data
//   peri_wstrb_o - byte strobes (only when MEM_BYTE_EN_EN is defined)
//   peri_ack_i   - completion, sampled while peri_req_o = 1
//   peri_rdata_i - read data, valid with peri_ack_i
interface vmem_stage_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              peri_req_o;
  logic              peri_we_o;
  logic [ADDR_W-1:0] peri_addr_o;
  logic [DATA_W-1:0] peri_wdata_o;
`ifdef MEM_BYTE_EN_EN
  logic [DATA_W/8-1:0] peri_wstrb_o;
`endif
  logic              peri_ack_i;
  logic [DATA_W-1:0] peri_rdata_i;

  modport master (
    output peri_req_o, peri_we_o, peri_addr_o, peri_wdata_o,
`ifdef MEM_BYTE_EN_EN
    output peri_wstrb_o,
`endif
    input  peri_ack_i, peri_rdata_i
  );

  modport slave (
    input  peri_req_o, peri_we_o, peri_addr_o, peri_wdata_o,
`ifdef MEM_BYTE_EN_EN
    input  peri_wstrb_o,
`endif
    output peri_ack_i, peri_rdata_i
  );
endinterface

// File: rtl/vmem_stage_dmem_bank.sv
// vmem_dmem_bank: DEPTH x DATA_W synchronous single-port RAM.
//   clk    - clock
//   en_wr  - write enable, active-low (matches the legacy dsram)
//   wstrb  - byte-lane write mask (tie to all ones for full-word writes)
//   addr   - word index
//   wdata  - write data
//   rdata  - read data, registered (read-first, one cycle after addr)
// Contents are never reset.
module vmem_dmem_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       en_wr,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);
  localparam int unsigned LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!en_wr) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/vmem_stage.sv
// vmem_stage: pipeline memory stage between EX and WB.
// Addresses below PERI_BASE hit the internal synchronous RAM (1-cycle load latency);
// higher addresses go out over the peripheral req/ack bus, stalling the pipe until
// ack or TIMEOUT (0 = no timeout).
// Optional feature macro: MEM_BYTE_EN_EN (adds wstrb_i / peri_wstrb_o, byte-lane stores).
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   mem_valid_i        - EX presents an access (accepted when !stall_o)
//   mem_write_i        - 1 = store, 0 = load
//   addr_i, wdata_i    - word-aligned byte address, store data
//   wstrb_i            - store byte strobes (MEM_BYTE_EN_EN only)
//   rdata_o            - load result, qualified by rdata_valid_o (1-cycle pulse)
//   stall_o            - stage busy with a peripheral access
//   err_o              - 1-cycle pulse on peripheral timeout
//   peri               - peripheral bus (vmem_stage_if master)
module vmem_stage
  import vmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned PERI_BASE = 'h0100,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef MEM_BYTE_EN_EN
  input  logic [DATA_W/8-1:0] wstrb_i,
`endif
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              stall_o,
  output logic              err_o,
  vmem_stage_if.master      peri
);
  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  vm_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              peri_we_q;
  logic [ADDR_W-1:0] peri_addr_q;
  logic [DATA_W-1:0] peri_wdata_q;
  logic [LANES-1:0]  peri_wstrb_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_ld;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_q, err_d;
  logic              local_rd_q, local_rd_d;
  logic              latch_en;
  logic              bank_en_wr;
  logic [LANES-1:0]  st_strb;
  logic [DATA_W-1:0] bank_rdata;
  logic              accept;
  logic              peri_hit;
  logic              timeout_hit;

`ifdef MEM_BYTE_EN_EN
  assign st_strb = wstrb_i;
`else
  assign st_strb = '1;
`endif

  assign accept      = mem_valid_i && (state_q == VM_IDLE);
  assign peri_hit    = vm_is_peri(32'(addr_i), 32'(PERI_BASE));
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  vmem_dmem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk   (clk),
    .en_wr (bank_en_wr),
    .wstrb (st_strb),
    .addr  (addr_i[OFF_W +: IDX_W]),
    .wdata (wdata_i),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= VM_IDLE;
      cnt_q         <= '0;
      peri_we_q     <= 1'b0;
      peri_addr_q   <= '0;
      peri_wdata_q  <= '0;
      peri_wstrb_q  <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      local_rd_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
      local_rd_q    <= local_rd_d;
      if (rdata_ld) rdata_q <= rdata_d;
      if (latch_en) begin
        peri_we_q    <= mem_write_i;
        peri_addr_q  <= addr_i;
        peri_wdata_q <= wdata_i;
        peri_wstrb_q <= st_strb;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    rdata_ld      = 1'b0;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    local_rd_d    = 1'b0;
    latch_en      = 1'b0;
    bank_en_wr    = 1'b1;
    unique case (state_q)
      VM_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (peri_hit) begin
            latch_en = 1'b1;
            state_d  = VM_PERI;
          end else if (mem_write_i) begin
            bank_en_wr = 1'b0;
          end else begin
            local_rd_d    = 1'b1;
            rdata_valid_d = 1'b1;
          end
        end
      end
      VM_PERI: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (peri.peri_ack_i) begin
          state_d = VM_IDLE;
          if (!peri_we_q) begin
            rdata_d       = peri.peri_rdata_i;
            rdata_ld      = 1'b1;
            rdata_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = VM_IDLE;
          err_d   = 1'b1;
          if (!peri_we_q) begin
            rdata_d       = '0;
            rdata_ld      = 1'b1;
            rdata_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = VM_IDLE;
    endcase
  end

  // The RAM output is already a register, so local loads select it directly
  // to keep the 1-cycle latency; rdata_q carries peripheral results.
  assign rdata_o       = local_rd_q ? bank_rdata : rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign err_o         = err_q;
  assign stall_o       = (state_q == VM_PERI);

  assign peri.peri_req_o   = (state_q == VM_PERI);
  assign peri.peri_we_o    = peri_we_q;
  assign peri.peri_addr_o  = peri_addr_q;
  assign peri.peri_wdata_o = peri_wdata_q;
`ifdef MEM_BYTE_EN_EN
  assign peri.peri_wstrb_o = peri_wstrb_q;
`endif
endmodule

// File: tb/tb_vmem_stage.sv
// tb_vmem_stage: self-checking bench for vmem_stage (DEPTH=16 to exercise address wrap, TIMEOUT=4).
// Byte-strobe checks are included when MEM_BYTE_EN_EN is defined.
module tb_vmem_stage;
  import vmem_pkg::*;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned PERI_BASE = 'h0100;
  localparam int unsigned TIMEOUT   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_valid_i;
  logic              mem_write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [3:0]        wstrb_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rdata_valid_o;
  logic              stall_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  // Reference memory: word index = (byte address / 4) mod DEPTH.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_vld [DEPTH];

  vmem_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pif ();

  vmem_stage #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .PERI_BASE (PERI_BASE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_valid_i   (mem_valid_i),
    .mem_write_i   (mem_write_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
`ifdef MEM_BYTE_EN_EN
    .wstrb_i       (wstrb_i),
`endif
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .stall_o       (stall_o),
    .err_o         (err_o),
    .peri          (pif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_valid_i = 1'b0;
    mem_write_i = 1'b0;
    addr_i      = '0;
    wdata_i     = '0;
    wstrb_i     = '0;
  endtask

  function automatic int unsigned widx(input logic [15:0] a);
    return (int'(a) / 4) % DEPTH;
  endfunction

  task automatic model_store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned i;
    logic [3:0] eff;
    logic [31:0] w;
    i = widx(a);
`ifdef MEM_BYTE_EN_EN
    eff = s;
`else
    eff = 4'hF;
`endif
    w = ref_mem[i];
    for (int b = 0; b < 4; b++) if (eff[b]) w[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[i] = w;
    if (eff == 4'hF) ref_vld[i] = 1'b1;
  endtask

  task automatic local_store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_valid_i = 1'b1; mem_write_i = 1'b1; addr_i = a; wdata_i = d; wstrb_i = s;
    step();
    chk("st_stall", stall_o, 0);
    chk("st_rvalid", rdata_valid_o, 0);
    model_store(a, d, s);
  endtask

  task automatic local_load(input logic [15:0] a);
    mem_valid_i = 1'b1; mem_write_i = 1'b0; addr_i = a; wdata_i = $urandom; wstrb_i = '0;
    step();
    chk("ld_stall", stall_o, 0);
    chk("ld_rvalid", rdata_valid_o, 1);
    if (ref_vld[widx(a)]) chk("ld_rdata", rdata_o, ref_mem[widx(a)]);
  endtask

  task automatic finish_local();
    idle_in();
    step();
    chk("idle_rvalid", rdata_valid_o, 0);
  endtask

  // ack_k = cycle (after accept at cycle 0) in which ack is driven; 0 = never.
  task automatic peri_op(input logic [15:0] a, input bit we, input logic [31:0] d,
                         input logic [3:0] s, input int unsigned ack_k,
                         input logic [31:0] ad, input bit hold, input logic [31:0] hd);
    int unsigned fin;
    bit tmo;
    tmo = !(ack_k != 0 && ack_k <= TIMEOUT);
    fin = tmo ? TIMEOUT : ack_k;
    mem_valid_i = 1'b1; mem_write_i = we; addr_i = a; wdata_i = d; wstrb_i = s;
    step();
    if (hold) begin
      mem_valid_i = 1'b1; mem_write_i = 1'b1; addr_i = '0; wdata_i = hd; wstrb_i = 4'hF;
    end else begin
      idle_in();
    end
    for (int unsigned c = 1; c <= fin; c++) begin
      chk("p_req", pif.peri_req_o, 1);
      chk("p_stall", stall_o, 1);
      chk("p_addr", pif.peri_addr_o, a);
      chk("p_we", pif.peri_we_o, we);
      if (we) chk("p_wdata", pif.peri_wdata_o, d);
`ifdef MEM_BYTE_EN_EN
      chk("p_wstrb", pif.peri_wstrb_o, s);
`endif
      chk("p_err_early", err_o, 0);
      chk("p_rvalid_early", rdata_valid_o, 0);
      pif.peri_ack_i   = (c == ack_k);
      pif.peri_rdata_i = (c == ack_k) ? ad : $urandom;
      step();
    end
    pif.peri_ack_i = 1'b0;
    chk("p_end_stall", stall_o, 0);
    chk("p_end_req", pif.peri_req_o, 0);
    chk("p_end_err", err_o, tmo);
    chk("p_end_rvalid", rdata_valid_o, !we);
    if (!we) chk("p_end_rdata", rdata_o, tmo ? 32'h0 : ad);
    step();
    if (hold) model_store(16'h0000, hd, 4'hF);
    idle_in();
    chk("p_post_err", err_o, 0);
    chk("p_post_rvalid", rdata_valid_o, 0);
    chk("p_post_stall", stall_o, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, rdata_o, 0);
    chk({tag, "_rvalid"}, rdata_valid_o, 0);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_req"}, pif.peri_req_o, 0);
    chk({tag, "_we"}, pif.peri_we_o, 0);
    chk({tag, "_addr"}, pif.peri_addr_o, 0);
    chk({tag, "_wdata"}, pif.peri_wdata_o, 0);
`ifdef MEM_BYTE_EN_EN
    chk({tag, "_wstrb"}, pif.peri_wstrb_o, 0);
`endif
  endtask

  initial begin
    logic [15:0] ra;
    logic [31:0] rd;
    logic [3:0]  rs;
    int unsigned op;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_vld[i] = 1'b0;
    end
    rst_n = 1'b0;
    idle_in();
    pif.peri_ack_i   = 1'b0;
    pif.peri_rdata_i = '0;
    #2;
    chk_all_zero("reset");
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // Local store then load, plus an aliased address (DEPTH words wrap).
    local_store(16'h0010, 32'hDEADBEEF, 4'hF);
    local_load(16'h0010);
    local_load(16'h0050);
    local_store(16'h0014, 32'hCAFEF00D, 4'hF);
    local_load(16'h0014);
    local_load(16'h0010);
    finish_local();

    // Peripheral load, ack in cycle 3.
    peri_op(16'h0200, 1'b0, 32'h0, 4'hF, 3, 32'h12345678, 1'b0, 32'h0);
    // Peripheral load with no ack: timeout, then a normal local load.
    peri_op(16'h0300, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 32'h0);
    local_load(16'h0010);
    finish_local();
    // Ack in the timeout cycle wins; minimum access (ack in cycle 1).
    peri_op(16'h0404, 1'b0, 32'h0, 4'hF, TIMEOUT, 32'hA5A5_0F0F, 1'b0, 32'h0);
    peri_op(16'h0100, 1'b0, 32'h0, 4'hF, 1, 32'h0BAD_CAFE, 1'b0, 32'h0);
    // Peripheral store, and a store timeout (err without rdata_valid).
    peri_op(16'hFFFC, 1'b1, 32'h1357_9BDF, 4'hA, 2, 32'h0, 1'b0, 32'h0);
    peri_op(16'h8000, 1'b1, 32'h2468_ACE0, 4'h3, 0, 32'h0, 1'b0, 32'h0);

`ifdef MEM_BYTE_EN_EN
    local_store(16'h0020, 32'hFFFFFFFF, 4'hF);
    local_store(16'h0020, 32'h00000000, 4'b0101);
    local_load(16'h0020);
    chk("byte_en_rdata", rdata_o, 32'hFF00FF00);
    finish_local();
`endif

    // Store to 0x0000 held on the bus during a peripheral stall.
    local_store(16'h0000, 32'h1111_1111, 4'hF);
    finish_local();
    peri_op(16'h0600, 1'b0, 32'h0, 4'hF, 3, 32'h7777_8888, 1'b1, 32'h5A5A_5A5A);
    local_load(16'h0000);
    chk("hold_rdata", rdata_o, 32'h5A5A_5A5A);
    finish_local();

    // Reset in the middle of a peripheral access.
    mem_valid_i = 1'b1; mem_write_i = 1'b0; addr_i = 16'h0400;
    step();
    idle_in();
    step();
    chk("mid_req", pif.peri_req_o, 1);
    rst_n = 1'b0;
    #2;
    chk_all_zero("mid_reset");
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      step();
      chk("rst_req", pif.peri_req_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_stall", stall_o, 0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      ra = 16'($urandom_range(0, (PERI_BASE / 4) - 1) * 4);
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
`ifndef MEM_BYTE_EN_EN
      rs = 4'hF;
`endif
      if (op < 4) begin
        local_store(ra, rd, rs);
      end else if (op < 8) begin
        local_load(ra);
      end else begin
        finish_local();
        ra = 16'($urandom_range(PERI_BASE / 4, 16'hFFFF / 4) * 4);
        peri_op(ra, 1'($urandom_range(0, 1)), rd, rs, $urandom_range(0, TIMEOUT + 2),
                $urandom, 1'b0, 32'h0);
      end
    end
    finish_local();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
